vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 178 +++++++++++++++++
 tb/tb_vga_scanout.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout
// Description : Monochrome VGA scan-out engine. Free-running horizontal and
//               vertical counters generate sync/enable timing. The frame buffer
//               is read one 16-bit word per 16 pixels, with 1-cycle read
//               latency. Each word is staged in a prefetch register and
//               serialised LSB-first through a shift register.
// Ports       : clk         - pixel clock
//               reset       - synchronous, active-low reset
//               rd_en       - frame-buffer read strobe (one cycle per word)
//               rd_addr     - frame-buffer word address
//               rd_data     - frame-buffer word, valid 1 cycle after rd_en
//               pixel       - monochrome pixel (0 outside the visible area)
//               de          - display enable, high on visible pixels
//               hsync       - horizontal sync, active-low
//               vsync       - vertical sync, active-low
//               frame_start - one-cycle pulse with pixel (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);

    localparam logic [c_HW-1:0] c_H_LAST      = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_PREFETCH  = c_HW'(c_H_TOTAL - 4);
    localparam logic [c_HW-1:0] c_H_ACT       = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_FETCH_END = c_HW'(H_ACTIVE - 4);
    localparam logic [c_HW-1:0] c_HS_START    = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END      = c_HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [c_VW-1:0] c_V_LAST      = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT       = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_ACT_LAST  = c_VW'(V_ACTIVE - 1);
    localparam logic [c_VW-1:0] c_VS_START    = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END      = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    // Scan position
    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;

    // Fetch path
    logic [15:0]     r_addr_cnt;
    logic            r_rd_en_d;
    logic [15:0]     r_prefetch;
    logic [15:0]     r_shift;

    // First pipeline stage of the video outputs (aligned with r_shift)
    logic            r_de1;
    logic            r_hs1;
    logic            r_vs1;
    logic            r_fs1;

    logic            w_h_wrap;
    logic            w_v_active;
    logic            w_visible;
    logic            w_fetch_frame0;
    logic            w_fetch_word0;
    logic            w_fetch_mid;
    logic            w_fetch;

    assign w_h_wrap   = (r_h == c_H_LAST);
    assign w_v_active = (r_v < c_V_ACT);
    assign w_visible  = w_v_active && (r_h < c_H_ACT);

    // Word 0 of a line is fetched 4 cycles before the line starts so it has
    // passed through rd_data and the prefetch register by h = 0. The frame's
    // very first fetch comes from the last (blank) line and restarts the
    // address sequence.
    assign w_fetch_frame0 = (r_h == c_H_PREFETCH) && (r_v == c_V_LAST);
    assign w_fetch_word0  = (r_h == c_H_PREFETCH) && (r_v < c_V_ACT_LAST);
    // Remaining words: 4 cycles ahead of each 16-pixel boundary, stopping
    // before the (nonexistent) word past the end of the line.
    assign w_fetch_mid    = w_v_active && (r_h[3:0] == 4'd12) && (r_h < c_H_FETCH_END);
    assign w_fetch        = w_fetch_frame0 || w_fetch_word0 || w_fetch_mid;

    // Reset parks the counters 4 cycles before pixel (0,0) so that the first
    // cycle after release issues the line-0 word-0 fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h <= c_H_PREFETCH;
            r_v <= c_V_LAST;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Address generation: r_addr_cnt holds the address of the next fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            r_addr_cnt <= '0;
            r_rd_en_d  <= 1'b0;
            r_prefetch <= '0;
        end else begin
            rd_en     <= w_fetch;
            r_rd_en_d <= rd_en;
            if (w_fetch_frame0) begin
                rd_addr    <= '0;
                r_addr_cnt <= 16'd1;
            end else if (w_fetch) begin
                rd_addr    <= r_addr_cnt;
                r_addr_cnt <= r_addr_cnt + 16'd1;
            end
            if (r_rd_en_d) begin
                r_prefetch <= rd_data;
            end
        end
    end

    // Stage 1: shift register and timing flags, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
            r_de1   <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_fs1   <= 1'b0;
        end else begin
            if (w_visible && (r_h[3:0] == 4'd0)) begin
                r_shift <= r_prefetch;
            end else begin
                r_shift <= {1'b0, r_shift[15:1]};
            end
            r_de1 <= w_visible;
            r_hs1 <= !((r_h >= c_HS_START) && (r_h < c_HS_END));
            // r_v only changes at the line boundary, so vsync edges land on h = 0.
            r_vs1 <= !((r_v >= c_VS_START) && (r_v < c_VS_END));
            r_fs1 <= (r_h == '0) && (r_v == '0);
        end
    end

    // Stage 2: registered outputs, two cycles behind the counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pixel       <= 1'b0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pixel       <= r_shift[0] & r_de1;
            de          <= r_de1;
            hsync       <= r_hs1;
            vsync       <= r_vs1;
            frame_start <= r_fs1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scanout
// Description : Self-checking bench for vga_scanout using reduced timing
//               parameters. A RAM model answers reads one cycle later, and a
//               scoreboard queue predicts the 2-cycle-delayed video outputs
//               from the scan position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

    localparam int HA    = 64;
    localparam int HFP   = 8;
    localparam int HSW   = 8;
    localparam int HBP   = 16;
    localparam int VA    = 6;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int VBP   = 3;
    localparam int HT    = HA + HFP + HSW + HBP;   // 96
    localparam int VT    = VA + VFP + VSW + VBP;   // 13
    localparam int WPL   = HA / 16;                // words per line
    localparam int FRAME = HT * VT;                // 1248 cycles

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data = 16'h0;
    logic        pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pixel      (pixel),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic px;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          k = 0;          // cycles since the last reset edge
    int          mode = 0;       // RAM content pattern
    bit          pend = 1'b0;
    logic [15:0] pend_addr = 16'h0;
    int          rd_count = 0;
    int          fs_count = 0;
    int          last_fs = -1;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, k, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int a);
        case (mode)
            0:       return 16'(a);
            1:       return 16'hAAAA;
            default: return (a == WPL) ? 16'h0001 : 16'h0000;
        endcase
    endfunction

    // Linear scan position of the counters at cycle c after reset release.
    function automatic int lin(input int c);
        return (FRAME - 4 + c) % FRAME;
    endfunction

    function automatic exp_t exp_at(input int p);
        int          h;
        int          v;
        logic [15:0] w;
        exp_t        e;
        h    = p % HT;
        v    = p / HT;
        e.de = (h < HA) && (v < VA);
        e.hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        e.vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        e.fs = (h == 0) && (v == 0);
        w    = word_of(v * WPL + h / 16);
        e.px = e.de ? w[h % 16] : 1'b0;
        return e;
    endfunction

    // Address fetched at scan position p, or -1 when no fetch is due.
    function automatic int fetch_at(input int p);
        int h;
        int v;
        int vn;
        h  = p % HT;
        v  = p / HT;
        vn = (v + 1) % VT;
        if (h == HT - 4) return (vn < VA) ? vn * WPL : -1;
        if ((v < VA) && (h % 16 == 12) && (h + 4 < HA)) return v * WPL + (h + 4) / 16;
        return -1;
    endfunction

    task automatic reset_checks();
        check_val("rst_rd_en", int'(rd_en), 0);
        check_val("rst_rd_addr", int'(rd_addr), 0);
        check_val("rst_pixel", int'(pixel), 0);
        check_val("rst_de", int'(de), 0);
        check_val("rst_fs", int'(frame_start), 0);
        check_val("rst_hsync", int'(hsync), 1);
        check_val("rst_vsync", int'(vsync), 1);
    endtask

    // One clock cycle: sample at the falling edge, answer reads, score outputs.
    task automatic tick();
        exp_t o;
        int   fa;
        @(negedge clk);
        if (!reset) begin
            k        = 0;
            rd_count = 0;
            fs_count = 0;
            last_fs  = -1;
            q.delete();
        end else begin
            k++;
        end

        rd_data   = pend ? word_of(int'(pend_addr)) : 16'($urandom);
        pend      = reset && rd_en;
        pend_addr = rd_addr;

        q.push_back(exp_at(lin(k)));
        if (!reset) begin
            reset_checks();
        end else begin
            if (q.size() > 2) begin
                o = q.pop_front();
                check_val("de", int'(de), int'(o.de));
                check_val("hsync", int'(hsync), int'(o.hs));
                check_val("vsync", int'(vsync), int'(o.vs));
                check_val("frame_start", int'(frame_start), int'(o.fs));
                check_val("pixel", int'(pixel), int'(o.px));
            end
            fa = fetch_at(lin(k - 1));
            check_val("rd_en", int'(rd_en), (fa >= 0) ? 1 : 0);
            if (fa >= 0) check_val("rd_addr", int'(rd_addr), fa);
            if (rd_en) rd_count++;
            if (frame_start) begin
                fs_count++;
                if (last_fs >= 0) check_val("fs_period", k - last_fs, FRAME);
                last_fs = k;
            end
            if (k == 1) begin
                check_val("first_rd_en", int'(rd_en), 1);
                check_val("first_rd_addr", int'(rd_addr), 0);
            end
            if (k == 5) check_val("de_before_rise", int'(de), 0);
            if (k == 6) begin
                check_val("de_rise", int'(de), 1);
                check_val("fs_rise", int'(frame_start), 1);
            end
            if (k == FRAME) begin
                check_val("rd_per_frame", rd_count, VA * WPL);
                check_val("fs_per_frame", fs_count, 1);
            end
        end
    endtask

    initial begin
        // Incrementing RAM contents, two full frames.
        mode  = 0;
        reset = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2 * FRAME + 20) tick();

        // Restart, then reset mid-line at h = 44, v = 3 where a fetch is due.
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3 * HT + 44 + 4) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (FRAME + 20) tick();

        // Alternating pixels on every word.
        reset = 1'b0;
        repeat (2) tick();
        mode  = 1;
        reset = 1'b1;
        repeat (FRAME + 10) tick();

        // Single set pixel at line 1, h = 0.
        reset = 1'b0;
        repeat (2) tick();
        mode  = 2;
        reset = 1'b1;
        repeat (FRAME + 10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
